obi_arbiter_2to1: RTL

- Two-master to one-slave OBI arbiter placed directly upstream of the SRAM wrapper.
- Lets two requesters, for example the instruction-fetch and LSU ports of a core, share one single-ported SRAM.
- Grants address phases round-robin.
- Records which master owns each outstanding transaction in an ID FIFO, so every response returns to the master that issued it.

---
 rtl/obi_arbiter_2to1.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/obi_arbiter_2to1.sv
// Two-master to one-slave OBI arbiter: round-robin address phase, in-order response routing via an ID FIFO.
// Latency: zero added cycles on request, grant and response paths (all combinational through).
// Backpressure: s_gnt_i stalls the selected master (lock holds it); a full ID FIFO masks s_req_o.

module obi_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module obi_arbiter_2to1 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);
  logic sel, sel_req, hs;
  logic lock_vld, lock_idx, prio;
  logic fifo_full, fifo_empty, head;

  always_comb begin
    sel = prio;
    if (lock_vld)                  sel = lock_idx;
    else if (m0_req_i ^ m1_req_i)  sel = m1_req_i;
  end

  assign sel_req = sel ? m1_req_i : m0_req_i;
  // Full masks the request even if a pop lands this cycle: no rvalid->gnt path.
  assign s_req_o = sel_req & ~fifo_full;
  assign hs      = s_req_o & s_gnt_i;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      s_we_o    = sel ? m1_we_i    : m0_we_i;
      s_be_o    = sel ? m1_be_i    : m0_be_i;
      s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign m0_gnt_o    = hs & ~sel;
  assign m1_gnt_o    = hs & sel;
  assign m0_rvalid_o = s_rvalid_i & ~fifo_empty & ~head;
  assign m1_rvalid_o = s_rvalid_i & ~fifo_empty & head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_idx <= 1'b0;
      prio     <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (hs) begin
        lock_vld <= 1'b0;
        prio     <= ~sel;
      end else if (s_req_o) begin
        lock_vld <= 1'b1;
        lock_idx <= sel;
      end else if (lock_vld && !sel_req) begin
        // Master withdrew a stalled request; just release the lock.
        lock_vld <= 1'b0;
      end
      if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  obi_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (hs),
    .push_dat (sel),
    .pop      (s_rvalid_i),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule
